ahb_slave_if: RTL

AHB slave front-end of the AHB-to-APB bridge. It sits directly downstream of the AHB master. It accepts pipelined AHB address and data phases, decodes the target peripheral, and buffers posted writes and reads in a 2-entry command FIFO. The APB-side controller consumes that FIFO through a valid/ready command port and returns read data through a response strobe.

---
 rtl/ahb_slave_if_if.sv | 44 ++++
 rtl/ahb_slave_if.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_if_if.sv
// AHB slave bus plus command/response port of the AHB-to-APB bridge front-end.
interface ahb_slave_if_if;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned NSEL = 3;

    // AHB side
    logic            hwrite;
    logic            hreadyin;
    logic [1:0]      htrans;
    logic [AW-1:0]   haddr;
    logic [DW-1:0]   hwdata;
    logic            hreadyout;
    logic [DW-1:0]   hrdata;
    logic [1:0]      hresp;

    // command FIFO head towards the APB controller
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [NSEL-1:0] cmd_sel;

    // read response from the APB controller
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;

    modport slave (
        input  hwrite, hreadyin, htrans, haddr, hwdata,
        output hreadyout, hrdata, hresp,
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata
    );

    modport master (
        output hwrite, hreadyin, htrans, haddr, hwdata,
        input  hreadyout, hrdata, hresp,
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB slave front-end: accepts pipelined transfers, decodes the peripheral
// select and queues posted writes/reads into a 2-entry command FIFO.
module ahb_slave_if #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SEL_SPAN  = 32'h0400_0000
) (
    input  logic           hclk,
    input  logic           hresetn,
    ahb_slave_if_if.slave  bus
);
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned NSEL  = 3;
    localparam int unsigned DEPTH = 2;

    // Decode thresholds carried at AW+1 bits so 3*SEL_SPAN cannot wrap
    localparam logic [AW:0] SPAN1 = {1'b0, SEL_SPAN};
    localparam logic [AW:0] SPAN2 = SPAN1 + SPAN1;
    localparam logic [AW:0] SPAN3 = SPAN2 + SPAN1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_RREQ,
        S_RWAIT,
        S_RDONE,
        S_ERR1,
        S_ERR2
    } state_t;

    typedef struct packed {
        logic            write;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [NSEL-1:0] sel;
    } cmd_t;

    state_t          state;
    cmd_t            fifo [DEPTH];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic [AW-1:0]   addr_q;
    logic [NSEL-1:0] sel_q;
    logic [DW-1:0]   hrdata_q;

    logic [AW-1:0]   offset;
    logic [NSEL-1:0] dec_sel;
    logic            in_range;
    logic            accept;
    state_t          accept_state;
    logic            pop;
    logic            room;
    logic            ready;
    logic [1:0]      resp;
    logic            push;
    cmd_t            push_cmd;
    cmd_t            head;

    // Peripheral decode of the current address phase; below-base wraps high
    always_comb begin
        offset   = bus.haddr - BASE_ADDR;
        dec_sel  = '0;
        in_range = 1'b1;
        if ({1'b0, offset} < SPAN1) begin
            dec_sel = 3'b001;
        end else if ({1'b0, offset} < SPAN2) begin
            dec_sel = 3'b010;
        end else if ({1'b0, offset} < SPAN3) begin
            dec_sel = 3'b100;
        end else begin
            in_range = 1'b0;
        end
    end

    // Address-phase acceptance and the state it leads to
    always_comb begin
        accept = ready && bus.hreadyin &&
                 ((bus.htrans == 2'd2) || (bus.htrans == 2'd3));
        if (!accept) begin
            accept_state = S_IDLE;
        end else if (!in_range) begin
            accept_state = S_ERR1;
        end else if (bus.hwrite) begin
            accept_state = S_WDATA;
        end else begin
            accept_state = S_RREQ;
        end
    end

    // FIFO room: a same-cycle pop frees the slot being written
    always_comb begin
        pop  = (count != 2'd0) && bus.cmd_ready;
        room = (count < 2'd2) || pop;
    end

    // Bus-side handshake and FIFO push as a function of state and room
    always_comb begin
        ready    = 1'b1;
        resp     = 2'b00;
        push     = 1'b0;
        push_cmd = '0;
        case (state)
            S_WDATA: begin
                if (room) begin
                    push           = 1'b1;
                    push_cmd.write = 1'b1;
                    push_cmd.addr  = addr_q;
                    push_cmd.wdata = bus.hwdata;
                    push_cmd.sel   = sel_q;
                end else begin
                    ready = 1'b0;
                end
            end
            S_RREQ: begin
                ready = 1'b0;
                if (room) begin
                    push           = 1'b1;
                    push_cmd.write = 1'b0;
                    push_cmd.addr  = addr_q;
                    push_cmd.wdata = '0;
                    push_cmd.sel   = sel_q;
                end
            end
            S_RWAIT: begin
                ready = 1'b0;
            end
            S_ERR1: begin
                ready = 1'b0;
                resp  = 2'b01;
            end
            S_ERR2: begin
                resp = 2'b01;
            end
            default: begin
            end
        endcase
    end

    // Transfer FSM, address-phase capture and read-data register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            sel_q    <= '0;
            hrdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= bus.haddr;
                sel_q  <= dec_sel;
            end
            case (state)
                S_IDLE, S_RDONE, S_ERR2: begin
                    state <= accept_state;
                end
                S_WDATA: begin
                    if (room) begin
                        state <= accept_state;
                    end
                end
                S_RREQ: begin
                    if (room) begin
                        state <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (bus.rsp_valid) begin
                        hrdata_q <= bus.rsp_rdata;
                        state    <= S_RDONE;
                    end
                end
                S_ERR1: begin
                    state <= S_ERR2;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-entry command FIFO storage, pointers and occupancy
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= push_cmd;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head entry and bus outputs
    always_comb begin
        head          = fifo[rd_ptr];
        bus.hreadyout = ready;
        bus.hresp     = resp;
        bus.hrdata    = hrdata_q;
        bus.cmd_valid = (count != 2'd0);
        bus.cmd_write = head.write;
        bus.cmd_addr  = head.addr;
        bus.cmd_wdata = head.wdata;
        bus.cmd_sel   = head.sel;
    end

endmodule
